// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN test pipeline's final classification stage.
package cnn_pkg;
    localparam int SCORE_W     = 32;
    localparam int NUM_CLASSES = 10;
    localparam int IDX_W       = 4;
    localparam int CNT_W       = 16;

    typedef logic signed [SCORE_W-1:0] score_t;
    typedef logic [IDX_W-1:0]          cls_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } argmax_state_t;

    localparam score_t   SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};
    localparam cls_idx_t LAST_IDX  = cls_idx_t'(NUM_CLASSES - 1);

    // One guard bit keeps best - second exact; the true result is non-negative and fits SCORE_W bits.
    function automatic logic [SCORE_W-1:0] margin_of(input score_t best, input score_t second);
        logic signed [SCORE_W:0] diff;
        diff = {best[SCORE_W-1], best} - {second[SCORE_W-1], second};
        return diff[SCORE_W-1:0];
    endfunction
endpackage

// File: rtl/top2_update.sv
// Combinational top-two tracker: folds one candidate score into the running best/second-best pair.
module top2_update
    import cnn_pkg::*;
(
    input  score_t   i_best,
    input  score_t   i_second,
    input  cls_idx_t i_best_idx,
    input  score_t   i_cand,
    input  cls_idx_t i_cand_idx,
    output score_t   o_best,
    output score_t   o_second,
    output cls_idx_t o_best_idx
);

    // Strict signed greater-than so an equal later score never displaces the lower index.
    always_comb begin
        o_best     = i_best;
        o_second   = i_second;
        o_best_idx = i_best_idx;
        if (i_cand > i_best) begin
            o_best     = i_cand;
            o_second   = i_best;
            o_best_idx = i_cand_idx;
        end else if (i_cand > i_second) begin
            o_second = i_cand;
        end else begin
            o_second = i_second;
        end
    end

endmodule

// File: rtl/argmax_classifier.sv
// Snapshots ten class scores on a rising fc_done, scans them one per cycle and
// presents the winning class, its score and the margin over the runner-up.
module argmax_classifier
    import cnn_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fc_done,
    input  logic [SCORE_W-1:0] prob_0,
    input  logic [SCORE_W-1:0] prob_1,
    input  logic [SCORE_W-1:0] prob_2,
    input  logic [SCORE_W-1:0] prob_3,
    input  logic [SCORE_W-1:0] prob_4,
    input  logic [SCORE_W-1:0] prob_5,
    input  logic [SCORE_W-1:0] prob_6,
    input  logic [SCORE_W-1:0] prob_7,
    input  logic [SCORE_W-1:0] prob_8,
    input  logic [SCORE_W-1:0] prob_9,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [IDX_W-1:0]   res_class,
    output logic [SCORE_W-1:0] res_score,
    output logic [SCORE_W-1:0] res_margin,
    output logic               busy,
    output logic               overrun,
    input  logic               clr_overrun,
    output logic [CNT_W-1:0]   frame_cnt
);

    argmax_state_t r_state;
    argmax_state_t w_next_state;

    logic               r_fc_done_q;
    score_t             r_score [NUM_CLASSES];
    cls_idx_t           r_idx;
    score_t             r_best;
    score_t             r_second;
    cls_idx_t           r_best_idx;

    logic               r_res_valid;
    logic [IDX_W-1:0]   r_res_class;
    logic [SCORE_W-1:0] r_res_score;
    logic [SCORE_W-1:0] r_res_margin;
    logic               r_busy;
    logic               r_overrun;
    logic [CNT_W-1:0]   r_frame_cnt;

    score_t   w_prob [NUM_CLASSES];
    logic     w_start;
    logic     w_accept;
    logic     w_capture;
    logic     w_scan_step;
    logic     w_scan_done;
    logic     w_set_ovr;
    score_t   w_nbest;
    score_t   w_nsecond;
    cls_idx_t w_nbest_idx;

    assign w_prob[0] = score_t'(prob_0);
    assign w_prob[1] = score_t'(prob_1);
    assign w_prob[2] = score_t'(prob_2);
    assign w_prob[3] = score_t'(prob_3);
    assign w_prob[4] = score_t'(prob_4);
    assign w_prob[5] = score_t'(prob_5);
    assign w_prob[6] = score_t'(prob_6);
    assign w_prob[7] = score_t'(prob_7);
    assign w_prob[8] = score_t'(prob_8);
    assign w_prob[9] = score_t'(prob_9);

    assign w_start  = fc_done & ~r_fc_done_q;
    assign w_accept = r_res_valid & res_ready;

    top2_update u_top2 (
        .i_best     (r_best),
        .i_second   (r_second),
        .i_best_idx (r_best_idx),
        .i_cand     (r_score[r_idx]),
        .i_cand_idx (r_idx),
        .o_best     (w_nbest),
        .o_second   (w_nsecond),
        .o_best_idx (w_nbest_idx)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a handshake coinciding with a new frame goes straight back to SCAN.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) w_next_state = SCAN;
                else         w_next_state = IDLE;
            end
            SCAN: begin
                if (r_idx == LAST_IDX) w_next_state = HOLD;
                else                   w_next_state = SCAN;
            end
            HOLD: begin
                if (w_accept) w_next_state = w_start ? SCAN : IDLE;
                else          w_next_state = HOLD;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Per-state control decode driving the datapath and output registers.
    always_comb begin
        w_capture   = 1'b0;
        w_scan_step = 1'b0;
        w_scan_done = 1'b0;
        w_set_ovr   = 1'b0;
        case (r_state)
            IDLE: begin
                w_capture = w_start;
            end
            SCAN: begin
                w_scan_step = 1'b1;
                w_scan_done = (r_idx == LAST_IDX);
                w_set_ovr   = w_start;
            end
            HOLD: begin
                w_capture = w_start & w_accept;
                w_set_ovr = w_start & ~w_accept;
            end
            default: begin
                w_capture = 1'b0;
            end
        endcase
    end

    // Score snapshot and running top-two scan state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fc_done_q <= 1'b0;
            for (int i = 0; i < NUM_CLASSES; i++) r_score[i] <= '0;
            r_idx      <= '0;
            r_best     <= '0;
            r_second   <= '0;
            r_best_idx <= '0;
        end else begin
            r_fc_done_q <= fc_done;
            if (w_capture) begin
                for (int i = 0; i < NUM_CLASSES; i++) r_score[i] <= w_prob[i];
                r_best     <= w_prob[0];
                r_best_idx <= '0;
                r_second   <= SCORE_MIN;
                r_idx      <= cls_idx_t'(1);
            end else if (w_scan_step) begin
                r_best     <= w_nbest;
                r_second   <= w_nsecond;
                r_best_idx <= w_nbest_idx;
                if (!w_scan_done) r_idx <= r_idx + cls_idx_t'(1);
            end
        end
    end

    // Result, status and frame-count output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid  <= 1'b0;
            r_res_class  <= '0;
            r_res_score  <= '0;
            r_res_margin <= '0;
            r_busy       <= 1'b0;
            r_overrun    <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_busy <= (w_next_state != IDLE);
            if (w_scan_done) begin
                r_res_valid  <= 1'b1;
                r_res_class  <= w_nbest_idx;
                r_res_score  <= w_nbest;
                r_res_margin <= margin_of(w_nbest, w_nsecond);
            end else if (w_accept) begin
                r_res_valid <= 1'b0;
            end
            if (w_accept) r_frame_cnt <= r_frame_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (w_set_ovr)        r_overrun <= 1'b1;
            else if (clr_overrun) r_overrun <= 1'b0;
        end
    end

    assign res_valid  = r_res_valid;
    assign res_class  = r_res_class;
    assign res_score  = r_res_score;
    assign res_margin = r_res_margin;
    assign busy       = r_busy;
    assign overrun    = r_overrun;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: doc/argmax_classifier.md
Name: argmax_classifier

Overview:
- Final stage of the CNN test pipeline, directly downstream of the fully-connected layer.
- Snapshots the ten 32-bit class scores on the rising edge of fc_done, then scans them serially (one class per cycle).
- Reports the winning digit, its score, and a confidence margin (best minus second-best) over a valid/ready result handshake.
- Also counts completed frames and flags frames dropped while the block is busy.

Parameters:
- SCORE_W, 32, width of each class score; signed two's complement.
- NUM_CLASSES, 10, number of scores scanned; fixed by the fc stage.
- IDX_W, 4, width of the class index.
- CNT_W, 16, width of the frame counter.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- fc_done  input  1  fc stage result-valid level; only its rising edge is significant.
- prob_0 .. prob_9  input  SCORE_W each  class scores, signed, stable while fc_done is high.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_class  output  IDX_W  winning class index, 0..9.
- res_score  output  SCORE_W  winning score, signed.
- res_margin  output  SCORE_W  unsigned difference best minus second-best.
- busy  output  1  high in SCAN or HOLD.
- overrun  output  1  sticky; a fc_done rising edge was dropped.
- clr_overrun  input  1  synchronous clear of overrun.
- frame_cnt  output  CNT_W  count of accepted results; wraps modulo 2^CNT_W.

Behaviour:
- Reset: rst_n low asynchronously clears all state.
  - State goes to IDLE; fc_done_q=0; all score registers=0.
  - Outputs: res_valid=0, res_class=0, res_score=0, res_margin=0, busy=0, overrun=0, frame_cnt=0.
  - Reset mid-SCAN or mid-HOLD abandons the frame; no result is produced.
- Edge detect: start = fc_done & ~fc_done_q; fc_done_q is registered every cycle.
  - If fc_done is already high at reset release, the first clock counts as a rising edge.
- IDLE, on start:
  - Capture prob_0..prob_9 into the score array.
  - Set best=score0, best_idx=0, second=most-negative SCORE_W value, idx=1.
  - Go to SCAN.
- SCAN, one comparison per cycle on score[idx], all comparisons signed:
  - If score > best: second<=best, best<=score, best_idx<=idx.
  - Else if score > second: second<=score.
  - Ties keep the lower index: strict greater-than only.
  - When idx==NUM_CLASSES-1, after processing go to HOLD and set res_valid=1; otherwise idx<=idx+1.
- Latency: start sampled at edge E0 gives res_valid=1 after edge E9 (9 cycles). Total frame-to-valid is 10 clocks from the first cycle fc_done is sampled high.
- HOLD:
  - res_class, res_score and res_margin are held stable while res_valid=1.
  - res_margin = best - second, computed at SCAN exit as SCORE_W+1-bit signed and stored as its low SCORE_W bits. This is always non-negative and fits.
  - res_valid & res_ready: frame_cnt++ (wraps 0xFFFF to 0x0000), res_valid<=0, go to IDLE.
  - If start occurs in the same cycle as the handshake, capture the new frame and go directly to SCAN. This is not an overrun.
- Overrun: start while in SCAN, or in HOLD without a same-cycle handshake, sets overrun=1. The dropped frame is ignored and the current frame is unaffected.
  - clr_overrun clears overrun; if start-overrun and clr_overrun coincide, set wins.
- Output registers and fc_done_q are the only sequential outputs besides the state, score array, idx, best, second and best_idx. No combinational path from the prob inputs to any output.

Decomposition:
- Shared package cnn_pkg holds:
  - SCORE_W, NUM_CLASSES, IDX_W.
  - typedef score_t (signed SCORE_W).
  - typedef cls_idx_t.
  - enum argmax_state_t {IDLE, SCAN, HOLD}.
  - SCORE_MIN constant.
- One combinational sub-module, top2_update: inputs best, second, best_idx, cand, cand_idx; outputs next best, second and best_idx. Verifiable standalone.

Test Plan:
- Scores 0..9 = {5,1,9,3,9,2,-4,0,7,8}, fc_done rises, res_ready=1 → res_valid high after exactly 9 edges past the capture edge; res_class=2 (tie with index 4 keeps the lower index); res_score=9; res_margin=0; frame_cnt=1.
- All scores negative {-10,-3,-7,-3,-20,-50,-9,-8,-100,-4} → res_class=1, res_score=-3, res_margin=0. Change to class1=-2 → res_class=1, res_margin=1.
- Extremes: class9=0x7FFFFFFF, all others 0x80000000 → res_class=9, res_margin=0xFFFFFFFF; no overflow.
- Backpressure: hold res_ready=0 for 20 cycles → outputs stable throughout. Pulse fc_done mid-HOLD → overrun=1 and result unchanged. Assert clr_overrun → overrun=0.
- Handshake and new fc_done rising edge in the same cycle → no overrun; the second frame's result appears 9 edges later; frame_cnt increments once per accepted result. Preset 0xFFFF then accept → wraps to 0.
- rst_n low during SCAN idx=5 → immediately res_valid=0, busy=0. After release with fc_done low, no result is produced until the next rising edge.
